// File: rtl/rd_arb_pkg.sv
// rd_arb_pkg: shared FSM encoding, parameter defaults and width helper for rd_req_arbiter
package rd_arb_pkg;
  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;
  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF = 512;
  localparam int MAX_OUTSTANDING_DEF = 16;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/tag_fifo.sv
// tag_fifo: show-ahead synchronous FIFO holding requester IDs of bursts in flight
module tag_fifo
  import rd_arb_pkg::*;
#(
  parameter int W = 2,
  parameter int DEPTH = 16,
  localparam int AW = clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push_ok, pop_ok;
  assign full = count == (AW + 1)'(DEPTH);
  assign empty = count == '0;
  assign push_ok = push && !full;
  assign pop_ok = pop && !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW + 1)'(push_ok) - (AW + 1)'(pop_ok);
    end
  end
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/rd_req_arbiter.sv
// rd_req_arbiter: round-robin sharing of one AXI burst-read channel among NUM_REQ engines,
// with in-order tag tracking to steer returning bursts back to their issuers.
module rd_req_arbiter
  import rd_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ID_W = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ),
  parameter int DATA_W = DATA_W_DEF,
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
  localparam int CNT_W = clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    s_rd_req,
  input  logic [8*NUM_REQ-1:0]  s_rd_len,
  input  logic [64*NUM_REQ-1:0] s_rd_address,
  output logic [NUM_REQ-1:0]    s_rd_req_ack,
  output logic                  m_rd_req,
  output logic [7:0]            m_rd_len,
  output logic [63:0]           m_rd_address,
  input  logic                  m_rd_req_ack,
  input  logic                  m_rvalid,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic                  m_rlast,
  output logic                  m_rready,
  output logic [NUM_REQ-1:0]    s_rvalid,
  output logic [DATA_W-1:0]     s_rdata,
  output logic                  s_rlast,
  input  logic [NUM_REQ-1:0]    s_rready,
  output logic [CNT_W-1:0]      outstanding,
  output logic                  err_orphan
);
  state_t state, state_nx;
  logic [ID_W-1:0] prio_ptr, gnt_id, sel_id, head;
  logic sel_vld, grant, push, pop, full, empty;
  // Lowest requester overall, then overridden by the lowest at or after prio_ptr: a cyclic search.
  always_comb begin
    sel_vld = 1'b0;
    sel_id = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (s_rd_req[k]) begin
        sel_vld = 1'b1;
        sel_id = ID_W'(k);
      end
    end
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (s_rd_req[k] && k >= int'(prio_ptr)) sel_id = ID_W'(k);
    end
  end
  always_comb begin
    grant = state == IDLE && sel_vld && !full;
    push = state == ISSUE && m_rd_req_ack;
    state_nx = state == IDLE ? (grant ? ISSUE : IDLE) : (m_rd_req_ack ? IDLE : ISSUE);
    m_rd_req = state == ISSUE;
    s_rd_req_ack = push ? NUM_REQ'(1) << gnt_id : '0;
    m_rready = !empty && s_rready[head];
    s_rvalid = (m_rvalid && !empty) ? NUM_REQ'(1) << head : '0;
    pop = m_rvalid && m_rready && m_rlast;
  end
  assign s_rdata = m_rdata;
  assign s_rlast = m_rlast;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_ptr <= '0;
      gnt_id <= '0;
      m_rd_len <= '0;
      m_rd_address <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (grant) begin
        gnt_id <= sel_id;
        m_rd_len <= s_rd_len[int'(sel_id)*8 +: 8];
        m_rd_address <= s_rd_address[int'(sel_id)*64 +: 64];
      end
      if (push) prio_ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
      if (m_rvalid && empty) err_orphan <= 1'b1;
    end
  end
  tag_fifo #(.W(ID_W), .DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .din(gnt_id),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(outstanding)
  );
endmodule

// File: tb/tb_rd_req_arbiter.sv
// tb_rd_req_arbiter: scoreboard bench for rd_req_arbiter; issued bursts are queued and
// checked against the steered return data.
module tb_rd_req_arbiter;
  localparam int N = 4;
  localparam int DW = 512;
  logic clk = 0;
  logic rst_n = 0;
  logic [N-1:0] s_rd_req = '0;
  logic [8*N-1:0] s_rd_len = '0;
  logic [64*N-1:0] s_rd_address = '0;
  logic [N-1:0] s_rd_req_ack;
  logic m_rd_req;
  logic [7:0] m_rd_len;
  logic [63:0] m_rd_address;
  logic m_rd_req_ack = 0;
  logic m_rvalid = 0;
  logic [DW-1:0] m_rdata = '0;
  logic m_rlast = 0;
  logic m_rready;
  logic [N-1:0] s_rvalid;
  logic [DW-1:0] s_rdata;
  logic s_rlast;
  logic [N-1:0] s_rready = '1;
  logic [4:0] outstanding;
  logic err_orphan;
  int checks = 0;
  int errors = 0;
  int exp_id_q[$];
  int exp_len_q[$];
  int exp_ptr = 0;

  rd_req_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .s_rd_req(s_rd_req), .s_rd_len(s_rd_len), .s_rd_address(s_rd_address),
    .s_rd_req_ack(s_rd_req_ack),
    .m_rd_req(m_rd_req), .m_rd_len(m_rd_len), .m_rd_address(m_rd_address),
    .m_rd_req_ack(m_rd_req_ack),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rready(m_rready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rlast(s_rlast), .s_rready(s_rready),
    .outstanding(outstanding), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drives one requester alone so the grant is forced, acks it and queues the burst.
  task automatic issue(input int id, input logic [7:0] len, input logic [63:0] addr);
    int n;
    s_rd_len[id*8 +: 8] = len;
    s_rd_address[id*64 +: 64] = addr;
    s_rd_req[id] = 1'b1;
    n = 0;
    while (m_rd_req !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (m_rd_req !== 1'b1 || m_rd_len !== len || m_rd_address !== addr)
      $display("FAIL issue id%0d: req=%b len=%0d addr=%h, want req=1 len=%0d addr=%h",
               id, m_rd_req, m_rd_len, m_rd_address, len, addr);
    m_rd_req_ack = 1'b1;
    #1;
    checks++;
    if (s_rd_req_ack !== N'(1) << id) begin
      errors++;
      $display("FAIL issue_ack id%0d: got %b want %b", id, s_rd_req_ack, N'(1) << id);
    end
    exp_id_q.push_back(id);
    exp_len_q.push_back(int'(len));
    exp_ptr = (id + 1) % N;
    @(negedge clk);
    m_rd_req_ack = 1'b0;
    s_rd_req[id] = 1'b0;
  endtask

  // Returns every queued burst in order and checks steering of each beat.
  task automatic return_bursts();
    int id, len;
    while (exp_id_q.size() > 0) begin
      id = exp_id_q.pop_front();
      len = exp_len_q.pop_front();
      for (int b = 0; b <= len; b++) begin
        m_rvalid = 1'b1;
        m_rlast = (b == len);
        m_rdata = {16{$urandom()}};
        #1;
        checks++;
        if (s_rvalid !== N'(1) << id || m_rready !== 1'b1 || s_rdata !== m_rdata || s_rlast !== m_rlast) begin
          errors++;
          $display("FAIL beat id%0d b%0d: s_rvalid=%b m_rready=%b s_rlast=%b, want s_rvalid=%b m_rready=1 s_rlast=%b",
                   id, b, s_rvalid, m_rready, s_rlast, N'(1) << id, m_rlast);
        end
        @(negedge clk);
      end
      m_rvalid = 1'b0;
      m_rlast = 1'b0;
      #1;
      checks++;
      if (outstanding !== 5'(exp_id_q.size())) begin
        errors++;
        $display("FAIL pop_count: outstanding=%0d want %0d", outstanding, exp_id_q.size());
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({m_rd_req, s_rd_req_ack, s_rvalid, m_rready, err_orphan} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: req=%b ack=%b rvalid=%b rready=%b orphan=%b, want all 0",
               m_rd_req, s_rd_req_ack, s_rvalid, m_rready, err_orphan);
    end
    checks++;
    if (m_rd_len !== 8'd0 || m_rd_address !== 64'd0 || outstanding !== 5'd0) begin
      errors++;
      $display("FAIL reset_data: len=%0d addr=%h outstanding=%0d, want 0", m_rd_len, m_rd_address, outstanding);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    s_rd_len[7:0] = 8'd63;
    s_rd_address[63:0] = 64'h1000;
    s_rd_req[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (m_rd_req !== 1'b1 || m_rd_len !== 8'd63 || m_rd_address !== 64'h1000) begin
      errors++;
      $display("FAIL single_req: req=%b len=%0d addr=%h, want 1 63 1000", m_rd_req, m_rd_len, m_rd_address);
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (m_rd_req !== 1'b1 || s_rd_req_ack !== '0) begin
        errors++;
        $display("FAIL single_hold: req=%b ack=%b, want 1 0000", m_rd_req, s_rd_req_ack);
      end
    end
    m_rd_req_ack = 1'b1;
    #1;
    checks++;
    if (s_rd_req_ack !== 4'b0001) begin
      errors++;
      $display("FAIL single_ack: got %b want 0001", s_rd_req_ack);
    end
    exp_id_q.push_back(0);
    exp_len_q.push_back(63);
    exp_ptr = 1;
    @(negedge clk);
    m_rd_req_ack = 1'b0;
    s_rd_req[0] = 1'b0;
    #1;
    checks++;
    if (m_rd_req !== 1'b0 || s_rd_req_ack !== '0 || outstanding !== 5'd1) begin
      errors++;
      $display("FAIL single_after: req=%b ack=%b outstanding=%0d, want 0 0000 1", m_rd_req, s_rd_req_ack, outstanding);
    end
    @(negedge clk);
    return_bursts();
  endtask

  task automatic test_round_robin();
    int exp_cnt[N];
    int act_cnt[N];
    int id;
    issue(3, 8'd0, 64'h0);
    for (int i = 0; i < N; i++) begin
      s_rd_len[i*8 +: 8] = 8'd0;
      s_rd_address[i*64 +: 64] = 64'h100 * (i + 1);
      exp_cnt[i] = 0;
      act_cnt[i] = 0;
    end
    s_rd_req = '1;
    m_rd_req_ack = 1'b1;
    for (int g = 0; g < 5; g++) begin
      id = (exp_ptr + g) % N;
      exp_cnt[id]++;
      exp_id_q.push_back(id);
      exp_len_q.push_back(0);
      @(negedge clk);
      for (int k = 0; k < N; k++) if (s_rd_req_ack[k]) act_cnt[k]++;
      checks++;
      if (m_rd_req !== 1'b1 || s_rd_req_ack !== N'(1) << id || m_rd_address !== 64'h100 * (id + 1)) begin
        errors++;
        $display("FAIL rr_grant g%0d: req=%b ack=%b addr=%h, want 1 %b %h",
                 g, m_rd_req, s_rd_req_ack, m_rd_address, N'(1) << id, 64'h100 * (id + 1));
      end
      if (g < 4) begin
        @(negedge clk);
        for (int k = 0; k < N; k++) if (s_rd_req_ack[k]) act_cnt[k]++;
        checks++;
        if (m_rd_req !== 1'b0 || s_rd_req_ack !== '0) begin
          errors++;
          $display("FAIL rr_gap g%0d: req=%b ack=%b, want 0 0000", g, m_rd_req, s_rd_req_ack);
        end
      end
    end
    @(negedge clk);
    s_rd_req = '0;
    m_rd_req_ack = 1'b0;
    exp_ptr = (exp_ptr + 5) % N;
    for (int k = 0; k < N; k++) begin
      checks++;
      if (act_cnt[k] != exp_cnt[k]) begin
        errors++;
        $display("FAIL rr_ack_count req%0d: got %0d want %0d", k, act_cnt[k], exp_cnt[k]);
      end
    end
    @(negedge clk);
    return_bursts();
  endtask

  task automatic test_steering();
    issue(2, 8'd1, 64'h2000);
    issue(0, 8'd0, 64'h3000);
    issue(1, 8'd2, 64'h4000);
    checks++;
    if (outstanding !== 5'd3) begin
      errors++;
      $display("FAIL steer_outstanding: got %0d want 3", outstanding);
    end
    return_bursts();
  endtask

  task automatic test_backpressure();
    issue(1, 8'd2, 64'h5000);
    void'(exp_id_q.pop_front());
    void'(exp_len_q.pop_front());
    m_rvalid = 1'b1;
    #1;
    checks++;
    if (s_rvalid !== 4'b0010 || m_rready !== 1'b1) begin
      errors++;
      $display("FAIL bp_beat0: s_rvalid=%b m_rready=%b, want 0010 1", s_rvalid, m_rready);
    end
    @(negedge clk);
    s_rready[1] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (m_rready !== 1'b0 || s_rvalid !== 4'b0010 || outstanding !== 5'd1) begin
        errors++;
        $display("FAIL bp_stall c%0d: m_rready=%b s_rvalid=%b outstanding=%0d, want 0 0010 1",
                 c, m_rready, s_rvalid, outstanding);
      end
      @(negedge clk);
    end
    s_rready = '1;
    for (int b = 1; b <= 2; b++) begin
      m_rlast = (b == 2);
      #1;
      checks++;
      if (m_rready !== 1'b1 || s_rvalid !== 4'b0010) begin
        errors++;
        $display("FAIL bp_resume b%0d: m_rready=%b s_rvalid=%b, want 1 0010", b, m_rready, s_rvalid);
      end
      @(negedge clk);
    end
    m_rvalid = 1'b0;
    m_rlast = 1'b0;
    #1;
    checks++;
    if (outstanding !== 5'd0) begin
      errors++;
      $display("FAIL bp_done: outstanding=%0d want 0", outstanding);
    end
    @(negedge clk);
  endtask

  task automatic test_full();
    int id;
    for (int i = 0; i < 16; i++) issue(i % N, 8'd0, 64'(i * 64));
    checks++;
    if (outstanding !== 5'd16) begin
      errors++;
      $display("FAIL full_count: got %0d want 16", outstanding);
    end
    s_rd_len[24 +: 8] = 8'd7;
    s_rd_address[192 +: 64] = 64'hABC0;
    s_rd_req[3] = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (m_rd_req !== 1'b0) begin
        errors++;
        $display("FAIL full_block: m_rd_req=%b want 0", m_rd_req);
      end
    end
    id = exp_id_q.pop_front();
    void'(exp_len_q.pop_front());
    m_rvalid = 1'b1;
    m_rlast = 1'b1;
    #1;
    checks++;
    if (s_rvalid !== N'(1) << id || m_rready !== 1'b1) begin
      errors++;
      $display("FAIL full_pop: s_rvalid=%b m_rready=%b, want %b 1", s_rvalid, m_rready, N'(1) << id);
    end
    @(negedge clk);
    m_rvalid = 1'b0;
    m_rlast = 1'b0;
    #1;
    checks++;
    if (m_rd_req !== 1'b0 || outstanding !== 5'd15) begin
      errors++;
      $display("FAIL full_same_cycle: req=%b outstanding=%0d, want 0 15", m_rd_req, outstanding);
    end
    @(negedge clk);
    checks++;
    if (m_rd_req !== 1'b1 || m_rd_len !== 8'd7 || m_rd_address !== 64'hABC0) begin
      errors++;
      $display("FAIL full_regrant: req=%b len=%0d addr=%h, want 1 7 abc0", m_rd_req, m_rd_len, m_rd_address);
    end
    m_rd_req_ack = 1'b1;
    #1;
    checks++;
    if (s_rd_req_ack !== 4'b1000) begin
      errors++;
      $display("FAIL full_ack: got %b want 1000", s_rd_req_ack);
    end
    exp_id_q.push_back(3);
    exp_len_q.push_back(7);
    exp_ptr = 0;
    @(negedge clk);
    m_rd_req_ack = 1'b0;
    s_rd_req[3] = 1'b0;
    return_bursts();
  endtask

  task automatic test_orphan_reset();
    m_rvalid = 1'b1;
    #1;
    checks++;
    if (m_rready !== 1'b0 || s_rvalid !== '0 || err_orphan !== 1'b0) begin
      errors++;
      $display("FAIL orphan_pre: m_rready=%b s_rvalid=%b err=%b, want 0 0000 0", m_rready, s_rvalid, err_orphan);
    end
    @(negedge clk);
    m_rvalid = 1'b0;
    checks++;
    if (err_orphan !== 1'b1) begin
      errors++;
      $display("FAIL orphan_set: err_orphan=%b want 1", err_orphan);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (err_orphan !== 1'b1) begin
      errors++;
      $display("FAIL orphan_sticky: err_orphan=%b want 1", err_orphan);
    end
    issue(2, 8'd3, 64'h6000);
    s_rd_req[0] = 1'b1;
    @(negedge clk);
    m_rvalid = 1'b1;
    #1;
    checks++;
    if (m_rd_req !== 1'b1 || s_rvalid !== 4'b0100 || outstanding !== 5'd1) begin
      errors++;
      $display("FAIL midburst: req=%b s_rvalid=%b outstanding=%0d, want 1 0100 1", m_rd_req, s_rvalid, outstanding);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({m_rd_req, s_rd_req_ack, s_rvalid, m_rready, err_orphan} !== '0 || outstanding !== 5'd0) begin
      errors++;
      $display("FAIL async_reset: req=%b ack=%b rvalid=%b rready=%b err=%b outstanding=%0d, want all 0",
               m_rd_req, s_rd_req_ack, s_rvalid, m_rready, err_orphan, outstanding);
    end
    checks++;
    if (m_rd_len !== 8'd0 || m_rd_address !== 64'd0) begin
      errors++;
      $display("FAIL async_reset_data: len=%0d addr=%h, want 0", m_rd_len, m_rd_address);
    end
    m_rvalid = 1'b0;
    s_rd_req = '0;
    exp_id_q.delete();
    exp_len_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_steering();
    test_backpressure();
    test_full();
    test_orphan_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
